// File: rtl/arch_defines_pkg.sv
// Shared architecture definitions: instruction class codes, memory access
// size codes, the memory request FSM encoding and small lane helpers.
`ifndef INSTR_LOAD
`define INSTR_LOAD 5'd3
`endif
`ifndef INSTR_STORE
`define INSTR_STORE 5'd4
`endif

package arch_defines;

  // Instruction classes that reach the data memory.
  localparam logic [4:0] INSTR_CLS_LOAD  = `INSTR_LOAD;
  localparam logic [4:0] INSTR_CLS_STORE = `INSTR_STORE;

  // Access size codes; code 11 behaves exactly like a word access.
  typedef enum logic [1:0] {
    MEM_SIZE_BYTE   = 2'b00,
    MEM_SIZE_HALF   = 2'b01,
    MEM_SIZE_WORD   = 2'b10,
    MEM_SIZE_WORD_X = 2'b11
  } mem_size_e;

  // Memory request controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Byte offset after forcing the access to its natural alignment.
  function automatic logic [1:0] align_offset(mem_size_e size, logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: return lo;
      MEM_SIZE_HALF: return {lo[1], 1'b0};
      default:       return 2'b00;
    endcase
  endfunction

  // True when the low address bits break natural alignment for the size.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return lo[0];
      default:       return (lo != 2'b00);
    endcase
  endfunction

  // Byte enables for an aligned offset.
  function automatic logic [3:0] byte_enables(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_SIZE_BYTE: return 4'b0001 << off;
      MEM_SIZE_HALF: return 4'b0011 << off;
      default:       return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand so every lane carries the right bytes.
  function automatic logic [31:0] steer_wdata(mem_size_e size, logic [31:0] data);
    case (size)
      MEM_SIZE_BYTE: return {4{data[7:0]}};
      MEM_SIZE_HALF: return {2{data[15:0]}};
      default:       return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_request_control_load_extract.sv
// load_extract: pulls the addressed byte/half out of an aligned read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_extract
  import arch_defines::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  mem_size_e   i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane and extend it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    w_byte = i_rdata[7:0];
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_offset)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    case (i_size)
      MEM_SIZE_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      MEM_SIZE_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default:       o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_request_control.sv
// mem_request_control: MEM-stage data memory request FSM (IDLE -> REQ -> DONE).
// Latches the access on entry to REQ, holds the request until mem_ack, and
// registers the extracted load result. Optional build macro
// MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a one-cycle
// DONE with misaligned=1 instead of a memory request.
module mem_request_control
  import arch_defines::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [4:0]            instr_type,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           read_data,
  output logic                  done,
  output logic                  misaligned
);

  mem_state_e            r_state;
  mem_state_e            w_next_state;
  logic                  w_stall;

  logic                  w_mem_op;
  logic                  w_is_store;
  logic                  w_trap;
  logic                  w_start;
  mem_size_e             w_size;
  logic [1:0]            w_off;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [1:0]            r_off;
  mem_size_e             r_size;
  logic                  r_signed;
  logic [31:0]           r_read_data;
  logic [31:0]           w_load_data;

  assign w_size     = mem_size_e'(mem_size);
  assign w_is_store = (instr_type == INSTR_CLS_STORE);
  assign w_mem_op   = valid && ((instr_type == INSTR_CLS_LOAD) || w_is_store);
  assign w_off      = align_offset(w_size, addr[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_size, addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // A real memory access starts only from IDLE and never for a trapped op.
  assign w_start = (r_state == ST_IDLE) && w_mem_op && !w_trap;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and stall decode.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          w_stall      = 1'b1;
          w_next_state = w_trap ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (mem_ack) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Capture the access on entry to REQ; register load data on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_off       <= '0;
      r_size      <= MEM_SIZE_BYTE;
      r_signed    <= 1'b0;
      r_read_data <= '0;
    end else begin
      if (w_start) begin
        r_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
        r_we     <= w_is_store;
        r_wdata  <= steer_wdata(w_size, store_data);
        r_be     <= byte_enables(w_size, w_off);
        r_off    <= w_off;
        r_size   <= w_size;
        r_signed <= mem_signed;
      end
      if ((r_state == ST_REQ) && mem_ack && !r_we) begin
        r_read_data <= w_load_data;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misaligned;

  // Flag is high only during the DONE cycle that follows a trapped op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misaligned <= 1'b0;
    else     r_misaligned <= (r_state == ST_IDLE) && w_mem_op && w_trap;
  end

  assign misaligned = r_misaligned;
`else
  assign misaligned = 1'b0;
`endif

  load_extract u_load_extract (
    .i_rdata  (mem_rdata),
    .i_offset (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load_data)
  );

  assign stall     = w_stall;
  assign mem_req   = (r_state == ST_REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_be    = mem_req ? r_be : 4'b0000;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign done      = (r_state == ST_DONE);
  assign read_data = r_read_data;

endmodule
